// File: rtl/neo_f0_pkg.sv
// Shared register codes, EXT_CTRL one-hot values and bus request type for the
// F0 system I/O block.
package neo_f0_pkg;

   localparam logic [2:0] REG_SLOT     = 3'b010;
   localparam logic [2:0] REG_LEDLATCH = 3'b011;
   localparam logic [2:0] REG_LEDDATA  = 3'b100;
   localparam logic [2:0] REG_RTCCTRL  = 3'b101;

   localparam logic [3:0] EXT_SLOT     = 4'b0001;
   localparam logic [3:0] EXT_LEDLATCH = 4'b0010;
   localparam logic [3:0] EXT_LEDDATA  = 4'b0100;
   localparam logic [3:0] EXT_RTCCTRL  = 4'b1000;
   localparam logic [3:0] EXT_NONE     = 4'b0000;

   localparam logic [5:0] STATUS_A_FILL = 6'b111111;

   typedef struct packed {
      logic [2:0] code;
      logic [7:0] data;
   } wr_req_t;

   // One-hot latch pulse for a decoded write; codes without a latch give zero.
   function automatic logic [3:0] ext_pulse(input logic [2:0] code);
      case (code)
         REG_SLOT:     return EXT_SLOT;
         REG_LEDLATCH: return EXT_LEDLATCH;
         REG_LEDDATA:  return EXT_LEDDATA;
         REG_RTCCTRL:  return EXT_RTCCTRL;
         default:      return EXT_NONE;
      endcase
   endfunction

endpackage

// File: rtl/neo_f0_sync_if.sv
// 68K-side bus of the F0 block: write/read strobes, address nibble and data.
interface neo_f0_sync_if;
   logic       nBITWD0;
   logic       nDIPRD1;
   logic [3:0] M68K_ADDR;
   logic [7:0] M68K_DATA_IN;
   logic [7:0] M68K_DATA_OUT;
   logic       M68K_DATA_OE;

   modport master (
      output nBITWD0, nDIPRD1, M68K_ADDR, M68K_DATA_IN,
      input  M68K_DATA_OUT, M68K_DATA_OE
   );

   modport slave (
      input  nBITWD0, nDIPRD1, M68K_ADDR, M68K_DATA_IN,
      output M68K_DATA_OUT, M68K_DATA_OE
   );
endinterface

// File: rtl/neo_sync_edge.sv
// Multi-stage input synchroniser with rise/fall pulses. Edges are only
// reported between two genuine samples, never against the reset preset.
module neo_sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic CLK,
   input  logic nRESET,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sr;
   logic              q_d;
   logic [STAGES:0]   vld_pipe;

   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         sr       <= {STAGES{RESET_VAL}};
         q_d      <= RESET_VAL;
         vld_pipe <= '0;
      end else begin
         sr       <= {sr[STAGES-2:0], d};
         q_d      <= sr[STAGES-1];
         vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
      end
   end

   assign q = sr[STAGES-1];

   // vld_pipe[STAGES] set means q_d holds a real sample, not the preset.
   assign rise = vld_pipe[STAGES] &  q & ~q_d;
   assign fall = vld_pipe[STAGES] & ~q &  q_d;

endmodule

// File: rtl/neo_f0_sync.sv
// F0 system I/O register block: slot select, LED and RTC control registers,
// one-hot external latch pulses and the synchronised STATUS_A read port.
module neo_f0_sync #(
   parameter int NUM_SLOTS   = 6,
   parameter int SEL_W       = 3,
   parameter int SYNC_STAGES = 2,
   parameter int PULSE_LEN   = 4
) (
   input  logic                 CLK,
   input  logic                 nRESET,
   neo_f0_sync_if.slave         bus,
   input  logic                 SYSTEMB,
   input  logic                 RTC_DOUT,
   input  logic                 RTC_TP,
   output logic [NUM_SLOTS-1:0] nSLOT,
   output logic [SEL_W-1:0]     SLOT_SEL,
   output logic                 SLOT_ERR,
   output logic [2:0]           LED_LATCH,
   output logic [7:0]           LED_DATA,
   output logic                 RTC_DIN,
   output logic                 RTC_CLK,
   output logic                 RTC_STROBE,
   output logic [3:0]           EXT_CTRL,
   output logic                 TP_TICK
);
   import neo_f0_pkg::*;

   localparam int CNT_W = $clog2(PULSE_LEN + 1);

   logic             wr_fall, tp_rise, tp_s, dout_s;
   logic             unused_wr_q, unused_wr_rise, unused_tp_fall;
   logic             unused_dout_rise, unused_dout_fall, unused_addr7;
   logic [SEL_W-1:0] slots;
   logic [2:0]       rtcctrl;
   logic [CNT_W-1:0] pulse_cnt;
   logic [3:0]       req_pulse;
   wr_req_t          req;

   neo_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_wr_sync (
      .CLK(CLK), .nRESET(nRESET), .d(bus.nBITWD0),
      .q(unused_wr_q), .rise(unused_wr_rise), .fall(wr_fall)
   );

   neo_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_tp_sync (
      .CLK(CLK), .nRESET(nRESET), .d(RTC_TP),
      .q(tp_s), .rise(tp_rise), .fall(unused_tp_fall)
   );

   neo_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_dout_sync (
      .CLK(CLK), .nRESET(nRESET), .d(RTC_DOUT),
      .q(dout_s), .rise(unused_dout_rise), .fall(unused_dout_fall)
   );

   // Address bit 7 is outside the decoded window.
   assign unused_addr7 = bus.M68K_ADDR[3];

   // Address and data are taken in the cycle the synchronised fall is seen.
   assign req       = '{code: bus.M68K_ADDR[2:0], data: bus.M68K_DATA_IN};
   assign req_pulse = ext_pulse(req.code);

   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         slots     <= '0;
         LED_LATCH <= '0;
         LED_DATA  <= '0;
         rtcctrl   <= '0;
         EXT_CTRL  <= '0;
         pulse_cnt <= '0;
         TP_TICK   <= 1'b0;
      end else begin
         TP_TICK <= tp_rise;

         if (pulse_cnt == CNT_W'(1)) begin
            EXT_CTRL  <= '0;
            pulse_cnt <= '0;
         end else if (pulse_cnt != '0) begin
            pulse_cnt <= pulse_cnt - CNT_W'(1);
         end

         if (wr_fall) begin
            case (req.code)
               REG_SLOT:     slots     <= req.data[SEL_W-1:0];
               REG_LEDLATCH: LED_LATCH <= req.data[5:3];
               REG_LEDDATA:  LED_DATA  <= req.data;
               REG_RTCCTRL:  rtcctrl   <= req.data[2:0];
               default: ;
            endcase
            // A latching write retriggers; other codes leave a live pulse alone.
            if (req_pulse != EXT_NONE) begin
               EXT_CTRL  <= req_pulse;
               pulse_cnt <= CNT_W'(PULSE_LEN);
            end
         end
      end
   end

   assign RTC_DIN    = rtcctrl[0];
   assign RTC_CLK    = rtcctrl[1];
   assign RTC_STROBE = rtcctrl[2];

   always_comb begin
      nSLOT    = '1;
      SLOT_SEL = '0;
      SLOT_ERR = 1'b0;
      if (SYSTEMB) begin
         SLOT_SEL = slots;
         SLOT_ERR = (int'(slots) >= NUM_SLOTS);
         for (int i = 0; i < NUM_SLOTS; i++)
            if (slots == SEL_W'(i)) nSLOT[i] = 1'b0;
      end
   end

   assign bus.M68K_DATA_OE  = !bus.nDIPRD1;
   assign bus.M68K_DATA_OUT = {dout_s, tp_s, STATUS_A_FILL};

endmodule
